// File: rtl/i40xx_pc_stack.sv
// i40xx_pc_stack
// Program counter, return-address stack and machine-cycle sequencer for the
// 40xx-family core. A machine cycle lasts NA+5 clocks:
//   A1..A(NA) : PC is driven onto the bus one nibble per clock (low first)
//   M1, M2    : memory phases (opcode returned by ROM)
//   E1..E3    : execute; the decoder command is applied on the E3 edge.
//
// Ports
//   cp2        : clock, all state changes on its rising edge
//   reset      : synchronous active-high reset
//   sync       : high during E3
//   phase      : one-hot phase (A1..A(NA), M1, M2, E1, E2, E3); this is the
//                sequencer state and can be probed directly
//   addr_nib   : PC nibble during A phases, 0 otherwise
//   addr_valid : high during A phases
//   cmd        : 0 INC, 1 HOLD, 2 JLONG, 3 JSHORT, 4 CALL, 5 RET (6/7 = INC)
//   target     : jump/call target
//   instr_end  : instruction boundary marker from the decoder
//   int_req    : level interrupt request
//   ei / di    : enable / disable interrupt pulses (di wins)
//   clr_flags  : clears ovf/unf
//   pc         : address being fetched this machine cycle
//   depth      : number of valid stack entries
//   int_en     : interrupt enable
//   int_ack    : one-clock pulse after an interrupt is taken
//   ovf / unf  : sticky stack overflow / underflow
//
// Handshake: there is no valid/ready pair here; cmd, target and instr_end
// are treated as valid only in E3 and are ignored in every other phase.

module i40xx_pc_stack #(
   parameter int          ADDR_W  = 12,
   parameter int          DEPTH   = 3,
   parameter logic [15:0] INT_VEC = 16'h0003,
   localparam int         NA      = ADDR_W / 4,
   localparam int         NP      = NA + 5,
   localparam int         DW      = $clog2(DEPTH + 1)
) (
   input  logic              cp2,
   input  logic              reset,
   output logic              sync,
   output logic [NP-1:0]     phase,
   output logic [3:0]        addr_nib,
   output logic              addr_valid,
   input  logic [2:0]        cmd,
   input  logic [ADDR_W-1:0] target,
   input  logic              instr_end,
   input  logic              int_req,
   input  logic              ei,
   input  logic              di,
   input  logic              clr_flags,
   output logic [ADDR_W-1:0] pc,
   output logic [DW-1:0]     depth,
   output logic              int_en,
   output logic              int_ack,
   output logic              ovf,
   output logic              unf
);

   typedef logic [ADDR_W-1:0]            addr_t;
   typedef logic [DEPTH-1:0][ADDR_W-1:0] stack_t;

   localparam logic [2:0] CMD_HOLD   = 3'd1;
   localparam logic [2:0] CMD_JLONG  = 3'd2;
   localparam logic [2:0] CMD_JSHORT = 3'd3;
   localparam logic [2:0] CMD_CALL   = 3'd4;
   localparam logic [2:0] CMD_RET    = 3'd5;

   localparam int      E3       = NP - 1;
   localparam addr_t   VEC      = INT_VEC[ADDR_W-1:0];
   // Low byte of the address: JSHORT replaces it and keeps the page.
   localparam addr_t   LOW_MASK = addr_t'(8'hFF);
   localparam logic [DW-1:0] FULL = DW'(DEPTH);

   // Entry 0 is the top of stack; older entries sit at higher indices.
   stack_t stk;

   stack_t        stk_n;
   logic [DW-1:0] depth_n;
   addr_t         pc_n;
   addr_t         pc_inc;
   logic          ovf_ev;
   logic          unf_ev;
   logic          take_int;

   // Shift everything down one slot; the oldest entry falls off the end.
   function automatic stack_t push_stk(input stack_t s, input addr_t v);
      stack_t r;
      r = s;
      for (int i = DEPTH - 1; i > 0; i--) r[i] = s[i-1];
      r[0] = v;
      return r;
   endfunction

   // Shift everything up one slot; the vacated bottom slot becomes 0.
   function automatic stack_t pop_stk(input stack_t s);
      stack_t r;
      r = s;
      for (int i = 0; i < DEPTH - 1; i++) r[i] = s[i+1];
      r[DEPTH-1] = '0;
      return r;
   endfunction

   assign pc_inc = pc + addr_t'(1);

   // Next-state of pc/stack. The command is resolved first; an interrupt
   // taken in the same E3 then pushes the command's resulting pc, so a
   // CALL+interrupt is two pushes and a RET+interrupt is pop then push.
   always_comb begin
      stk_n    = stk;
      depth_n  = depth;
      pc_n     = pc;
      ovf_ev   = 1'b0;
      unf_ev   = 1'b0;
      take_int = 1'b0;
      if (phase[E3]) begin
         case (cmd)
            CMD_HOLD:   pc_n = pc;
            CMD_JLONG:  pc_n = target;
            CMD_JSHORT: pc_n = (pc & ~LOW_MASK) | (target & LOW_MASK);
            CMD_CALL: begin
               stk_n = push_stk(stk_n, pc_inc);
               if (depth_n == FULL) ovf_ev = 1'b1;
               else                 depth_n = depth_n + DW'(1);
               pc_n = target;
            end
            CMD_RET: begin
               if (depth_n == '0) begin
                  pc_n   = '0;
                  unf_ev = 1'b1;
               end else begin
                  pc_n    = stk_n[0];
                  stk_n   = pop_stk(stk_n);
                  depth_n = depth_n - DW'(1);
               end
            end
            default:    pc_n = pc_inc;
         endcase

         take_int = int_req & int_en & instr_end;
         if (take_int) begin
            stk_n = push_stk(stk_n, pc_n);
            if (depth_n == FULL) ovf_ev = 1'b1;
            else                 depth_n = depth_n + DW'(1);
            pc_n = VEC;
         end
      end
   end

   always_ff @(posedge cp2) begin
      if (reset) begin
         phase   <= NP'(1);
         pc      <= '0;
         stk     <= '0;
         depth   <= '0;
         int_en  <= 1'b0;
         int_ack <= 1'b0;
         ovf     <= 1'b0;
         unf     <= 1'b0;
      end else begin
         phase   <= {phase[NP-2:0], phase[NP-1]};
         pc      <= pc_n;
         stk     <= stk_n;
         depth   <= depth_n;
         int_ack <= take_int;
         // A fresh event beats a simultaneous clear.
         ovf     <= ovf_ev | (ovf & ~clr_flags);
         unf     <= unf_ev | (unf & ~clr_flags);
         // Taking an interrupt masks further ones, even against an ei pulse.
         if (take_int || di) int_en <= 1'b0;
         else if (ei)        int_en <= 1'b1;
      end
   end

   assign sync       = phase[E3];
   assign addr_valid = |phase[NA-1:0];

   always_comb begin
      addr_nib = 4'h0;
      for (int k = 0; k < NA; k++) begin
         if (phase[k]) addr_nib = pc[4*k +: 4];
      end
   end

endmodule

// File: tb/tb_i40xx_pc_stack.sv
// Directed testbench for i40xx_pc_stack: a 12-bit/depth-3 instance covers
// counting, jumps, stack overflow/underflow and interrupts; a 16-bit
// instance covers the 9-phase cycle, 4 address nibbles and wrap.

module tb_i40xx_pc_stack;

   localparam logic [2:0] CMD_INC    = 3'd0;
   localparam logic [2:0] CMD_JLONG  = 3'd2;
   localparam logic [2:0] CMD_JSHORT = 3'd3;
   localparam logic [2:0] CMD_CALL   = 3'd4;
   localparam logic [2:0] CMD_RET    = 3'd5;

   // ---------------- clock / reset ----------------
   logic cp2 = 1'b0;
   always #5 cp2 = ~cp2;

   // ---------------- DUT A: ADDR_W=12, DEPTH=3 ----------------
   logic        a_reset, a_instr_end, a_int_req, a_ei, a_di, a_clr;
   logic [2:0]  a_cmd;
   logic [11:0] a_target;
   logic        a_sync, a_av, a_int_en, a_int_ack, a_ovf, a_unf;
   logic [7:0]  a_phase;
   logic [3:0]  a_nib;
   logic [11:0] a_pc;
   logic [1:0]  a_depth;

   i40xx_pc_stack #(.ADDR_W(12), .DEPTH(3)) dut_a (
      .cp2(cp2), .reset(a_reset), .sync(a_sync), .phase(a_phase),
      .addr_nib(a_nib), .addr_valid(a_av), .cmd(a_cmd), .target(a_target),
      .instr_end(a_instr_end), .int_req(a_int_req), .ei(a_ei), .di(a_di),
      .clr_flags(a_clr), .pc(a_pc), .depth(a_depth), .int_en(a_int_en),
      .int_ack(a_int_ack), .ovf(a_ovf), .unf(a_unf)
   );

   // ---------------- DUT B: ADDR_W=16, DEPTH=3 ----------------
   logic        b_reset, b_instr_end, b_int_req, b_ei, b_di, b_clr;
   logic [2:0]  b_cmd;
   logic [15:0] b_target;
   logic        b_sync, b_av, b_int_en, b_int_ack, b_ovf, b_unf;
   logic [8:0]  b_phase;
   logic [3:0]  b_nib;
   logic [15:0] b_pc;
   logic [1:0]  b_depth;

   i40xx_pc_stack #(.ADDR_W(16), .DEPTH(3)) dut_b (
      .cp2(cp2), .reset(b_reset), .sync(b_sync), .phase(b_phase),
      .addr_nib(b_nib), .addr_valid(b_av), .cmd(b_cmd), .target(b_target),
      .instr_end(b_instr_end), .int_req(b_int_req), .ei(b_ei), .di(b_di),
      .clr_flags(b_clr), .pc(b_pc), .depth(b_depth), .int_en(b_int_en),
      .int_ack(b_int_ack), .ovf(b_ovf), .unf(b_unf)
   );

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_fail   = 0;
   logic [11:0] exp_q[$];   // expected return addresses, newest at back

   task automatic check_eq(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic timeout(input string tag);
      n_checks++;
      n_fail++;
      $display("FAIL %s: timed out waiting for sync", tag);
   endtask

   // Depth-3 model: pushing onto a full stack drops the oldest entry.
   task automatic sb_push(input logic [11:0] v);
      if (exp_q.size() == 3) void'(exp_q.pop_front());
      exp_q.push_back(v);
   endtask

   function automatic logic [11:0] sb_pop();
      if (exp_q.size() == 0) return 12'h000;
      return exp_q.pop_back();
   endfunction

   // ---------------- driver tasks ----------------
   // Wait (bounded) for E3, present a command, and return at the negedge
   // just after the E3 edge, i.e. in A1 of the next machine cycle.
   task automatic mc_a(input logic [2:0] c, input logic [11:0] t, input logic ie);
      int n = 0;
      while (a_sync !== 1'b1 && n < 20) begin @(negedge cp2); n++; end
      if (a_sync !== 1'b1) timeout("a_e3_wait");
      a_cmd = c; a_target = t; a_instr_end = ie;
      @(negedge cp2);
      a_cmd = CMD_INC; a_instr_end = 1'b0;
   endtask

   task automatic mc_b(input logic [2:0] c, input logic [15:0] t);
      int n = 0;
      while (b_sync !== 1'b1 && n < 20) begin @(negedge cp2); n++; end
      if (b_sync !== 1'b1) timeout("b_e3_wait");
      b_cmd = c; b_target = t; b_instr_end = 1'b1;
      @(negedge cp2);
      b_cmd = CMD_INC; b_instr_end = 1'b0;
   endtask

   task automatic pulse_a_reset();
      a_reset = 1'b1; @(negedge cp2); a_reset = 1'b0;
   endtask

   task automatic pulse_a_ei();
      a_ei = 1'b1; @(negedge cp2); a_ei = 1'b0;
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      n_fail++;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1);
   end

   // ---------------- stimulus ----------------
   initial begin
      a_reset = 1'b1; a_cmd = CMD_INC; a_target = '0; a_instr_end = 1'b0;
      a_int_req = 1'b0; a_ei = 1'b0; a_di = 1'b0; a_clr = 1'b0;
      b_reset = 1'b1; b_cmd = CMD_INC; b_target = '0; b_instr_end = 1'b0;
      b_int_req = 1'b0; b_ei = 1'b0; b_di = 1'b0; b_clr = 1'b0;
      @(negedge cp2);
      @(negedge cp2);
      a_reset = 1'b0; b_reset = 1'b0;

      // Reset state
      check_eq("rst_pc",    a_pc, 12'h000);
      check_eq("rst_phase", a_phase, 8'h01);
      check_eq("rst_depth", a_depth, 2'd0);
      check_eq("rst_flags", {a_int_en, a_int_ack, a_ovf, a_unf}, 4'b0000);
      check_eq("rst_sync",  a_sync, 1'b0);

      // INC counting
      for (int i = 1; i <= 3; i++) begin
         mc_a(CMD_INC, 12'h000, 1'b0);
         check_eq($sformatf("inc_pc%0d", i), a_pc, 12'(i));
      end

      // Address nibbles and sync rate
      mc_a(CMD_JLONG, 12'h123, 1'b0);
      check_eq("jlong_pc", a_pc, 12'h123);
      check_eq("nib_a1", a_nib, 4'h3);
      check_eq("av_a1",  a_av, 1'b1);
      @(negedge cp2);
      check_eq("nib_a2", a_nib, 4'h2);
      @(negedge cp2);
      check_eq("nib_a3", a_nib, 4'h1);
      @(negedge cp2);
      check_eq("nib_m1", a_nib, 4'h0);
      check_eq("av_m1",  a_av, 1'b0);
      begin
         int cnt = 0;
         for (int i = 0; i < 16; i++) begin
            @(negedge cp2);
            cnt += int'(a_sync);
         end
         check_eq("sync_per_16", cnt, 2);
      end

      // JSHORT keeps the page; INC wraps
      mc_a(CMD_JLONG, 12'h2FE, 1'b0);
      mc_a(CMD_JSHORT, 12'h045, 1'b0);
      check_eq("jshort_pc", a_pc, 12'h245);
      mc_a(CMD_JLONG, 12'hFFF, 1'b0);
      mc_a(CMD_INC, 12'h000, 1'b0);
      check_eq("inc_wrap", a_pc, 12'h000);

      // Call chain with overflow, then returns with underflow
      mc_a(CMD_JLONG, 12'h010, 1'b0);
      mc_a(CMD_CALL, 12'h100, 1'b0); sb_push(12'h011);
      mc_a(CMD_CALL, 12'h200, 1'b0); sb_push(12'h101);
      mc_a(CMD_CALL, 12'h300, 1'b0); sb_push(12'h201);
      check_eq("call3_depth", a_depth, 2'd3);
      check_eq("call3_ovf", a_ovf, 1'b0);
      mc_a(CMD_CALL, 12'h400, 1'b0); sb_push(12'h301);
      check_eq("call4_pc", a_pc, 12'h400);
      check_eq("call4_depth", a_depth, 2'd3);
      check_eq("call4_ovf", a_ovf, 1'b1);
      for (int i = 0; i < 3; i++) begin
         mc_a(CMD_RET, 12'h000, 1'b0);
         check_eq($sformatf("ret%0d_pc", i), a_pc, sb_pop());
      end
      check_eq("ret3_depth", a_depth, 2'd0);
      check_eq("ret3_unf", a_unf, 1'b0);
      mc_a(CMD_RET, 12'h000, 1'b0);
      check_eq("ret4_pc", a_pc, sb_pop());
      check_eq("ret4_unf", a_unf, 1'b1);
      check_eq("ret4_depth", a_depth, 2'd0);
      a_clr = 1'b1; @(negedge cp2); a_clr = 1'b0;
      check_eq("clr_flags", {a_ovf, a_unf}, 2'b00);

      // Interrupt taken at an instruction boundary
      mc_a(CMD_JLONG, 12'h050, 1'b0);
      pulse_a_ei();
      check_eq("ei_int_en", a_int_en, 1'b1);
      a_int_req = 1'b1;
      mc_a(CMD_INC, 12'h000, 1'b1);
      check_eq("int_pc", a_pc, 12'h003);
      check_eq("int_depth", a_depth, 2'd1);
      check_eq("int_ack_hi", a_int_ack, 1'b1);
      check_eq("int_en_clr", a_int_en, 1'b0);
      @(negedge cp2);
      check_eq("int_ack_lo", a_int_ack, 1'b0);
      a_int_req = 1'b0;
      mc_a(CMD_RET, 12'h000, 1'b0);
      check_eq("int_ret_pc", a_pc, 12'h051);

      // Request held without instr_end is deferred
      pulse_a_ei();
      a_int_req = 1'b1;
      mc_a(CMD_INC, 12'h000, 1'b0);
      check_eq("defer_pc", a_pc, 12'h052);
      check_eq("defer_ack", a_int_ack, 1'b0);
      mc_a(CMD_INC, 12'h000, 1'b1);
      check_eq("late_int_pc", a_pc, 12'h003);
      a_int_req = 1'b0;
      mc_a(CMD_RET, 12'h000, 1'b0);
      check_eq("late_ret_pc", a_pc, 12'h053);

      // di wins over ei
      pulse_a_ei();
      a_ei = 1'b1; a_di = 1'b1; @(negedge cp2); a_ei = 1'b0; a_di = 1'b0;
      check_eq("ei_di_prio", a_int_en, 1'b0);

      // CALL and interrupt in the same E3: two pushes
      pulse_a_ei();
      a_int_req = 1'b1;
      mc_a(CMD_CALL, 12'h300, 1'b1);
      a_int_req = 1'b0;
      check_eq("callint_pc", a_pc, 12'h003);
      check_eq("callint_depth", a_depth, 2'd2);
      mc_a(CMD_RET, 12'h000, 1'b0);
      check_eq("callint_ret1", a_pc, 12'h300);
      mc_a(CMD_RET, 12'h000, 1'b0);
      check_eq("callint_ret2", a_pc, 12'h054);

      // Reset in M2 after a CALL, with unf and int_en set
      pulse_a_ei();
      mc_a(CMD_RET, 12'h000, 1'b0);
      check_eq("pre_rst_unf", a_unf, 1'b1);
      mc_a(CMD_CALL, 12'h700, 1'b0);
      check_eq("pre_rst_depth", a_depth, 2'd1);
      for (int i = 0; i < 4; i++) @(negedge cp2);
      check_eq("pre_rst_m2", a_phase, 8'h10);
      pulse_a_reset();
      check_eq("mrst_pc", a_pc, 12'h000);
      check_eq("mrst_depth", a_depth, 2'd0);
      check_eq("mrst_phase", a_phase, 8'h01);
      check_eq("mrst_flags", {a_int_en, a_int_ack, a_ovf, a_unf}, 4'b0000);

      // ---- 16-bit instance ----
      b_reset = 1'b1; @(negedge cp2); b_reset = 1'b0;
      check_eq("b_rst_pc", b_pc, 16'h0000);
      check_eq("b_rst_phase", b_phase, 9'h001);
      mc_b(CMD_JLONG, 16'hABCD);
      check_eq("b_nib_a1", b_nib, 4'hD);
      @(negedge cp2);
      check_eq("b_nib_a2", b_nib, 4'hC);
      @(negedge cp2);
      check_eq("b_nib_a3", b_nib, 4'hB);
      @(negedge cp2);
      check_eq("b_nib_a4", b_nib, 4'hA);
      check_eq("b_av_a4", b_av, 1'b1);
      @(negedge cp2);
      check_eq("b_av_m1", b_av, 1'b0);
      begin
         int n = 0;
         while (b_sync !== 1'b1 && n < 20) begin @(negedge cp2); n++; end
         if (b_sync !== 1'b1) timeout("b_len_wait");
         n = 0;
         do begin @(negedge cp2); n++; end while (b_sync !== 1'b1 && n < 20);
         check_eq("b_cycle_len", n, 9);
      end
      mc_b(CMD_JLONG, 16'hFFFF);
      mc_b(CMD_INC, 16'h0000);
      check_eq("b_inc_wrap", b_pc, 16'h0000);
      mc_b(CMD_CALL, 16'h1234);
      check_eq("b_call_depth", b_depth, 2'd1);
      for (int i = 0; i < 5; i++) @(negedge cp2);
      check_eq("b_pre_rst_m2", b_phase, 9'h020);
      b_reset = 1'b1; @(negedge cp2); b_reset = 1'b0;
      check_eq("b_mrst_pc", b_pc, 16'h0000);
      check_eq("b_mrst_depth", b_depth, 2'd0);
      check_eq("b_mrst_phase", b_phase, 9'h001);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
